// File: rtl/thymesisflow_credit_return_if.sv
// Credit-return port bundle: slot events and flush in, credit return
// handshake plus status out. The slave modport faces the credit manager.
interface thymesisflow_credit_return_if #(
  parameter int MSB = 3
);
  logic         slot_alloc;
  logic         slot_freed;
  logic         flush;
  logic         credit_return_valid;
  logic [MSB:0] credit_return_count;
  logic         credit_return_ready;
  logic [MSB:0] occupancy;
  logic         err_alloc;
  logic         err_free;

  modport master (
    output slot_alloc, slot_freed, flush, credit_return_ready,
    input  credit_return_valid, credit_return_count, occupancy, err_alloc, err_free
  );

  modport slave (
    input  slot_alloc, slot_freed, flush, credit_return_ready,
    output credit_return_valid, credit_return_count, occupancy, err_alloc, err_free
  );
endinterface

// File: rtl/thymesisflow_credit_return.sv
// Receive-side credit manager: tracks buffer occupancy, batches freed slots
// into credit returns (threshold, idle timeout or flush) and offers them to the sender.
module thymesisflow_credit_return #(
  parameter int MSB              = 3,
  parameter int MAX_CREDITS      = 8,
  parameter int RETURN_THRESHOLD = 4,
  parameter int FLUSH_TIMEOUT    = 16
) (
  input  logic                           clock,
  input  logic                           resetn,
  thymesisflow_credit_return_if.slave    bus
);

  localparam logic [MSB:0] ZERO    = (MSB+1)'(0);
  localparam logic [MSB:0] ONE     = (MSB+1)'(1);
  localparam logic [MSB:0] MAX_C   = (MSB+1)'(MAX_CREDITS);
  localparam logic [MSB:0] THRESH  = (MSB+1)'(RETURN_THRESHOLD);
  localparam logic [7:0]   TIMEOUT = 8'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [MSB:0] occ_q, occ_d;
  logic [MSB:0] pend_q, pend_d;
  logic [MSB:0] sender_q, sender_d;
  logic [MSB:0] latch_q, latch_d;
  logic [7:0]   timer_q, timer_d;
  logic         valid_q, valid_d;
  logic         err_alloc_q, err_alloc_d;
  logic         err_free_q, err_free_d;
  logic         hs, alloc_ok, free_ok, trigger;

  // Next-state logic; the latch doubles as the offered count (MAX_C while advertising in INIT)
  always_comb begin
    hs       = valid_q & bus.credit_return_ready;
    alloc_ok = bus.slot_alloc & (sender_q != ZERO);
    free_ok  = bus.slot_freed & (occ_q != ZERO);
    trigger  = 1'b0;
    state_d  = state_q;
    latch_d  = latch_q;
    timer_d  = 8'd0;
    case (state_q)
      ST_INIT: begin
        if (hs) begin
          state_d = ST_IDLE;
          latch_d = ZERO;
        end else begin
          state_d = ST_INIT;
          latch_d = MAX_C;
        end
      end
      ST_IDLE: begin
        trigger = (pend_q >= THRESH) ||
                  ((bus.flush || (timer_q == TIMEOUT)) && (pend_q != ZERO));
        if (trigger) begin
          state_d = ST_SEND;
          latch_d = pend_q;
        end else if (pend_q != ZERO) begin
          timer_d = (timer_q == TIMEOUT) ? TIMEOUT : timer_q + 8'd1;
        end else begin
          timer_d = 8'd0;
        end
      end
      ST_SEND: begin
        if (hs) begin
          state_d = ST_IDLE;
          latch_d = ZERO;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_INIT;
        latch_d = ZERO;
      end
    endcase
    sender_d    = sender_q + (hs ? latch_q : ZERO) - (alloc_ok ? ONE : ZERO);
    occ_d       = occ_q + (alloc_ok ? ONE : ZERO) - (free_ok ? ONE : ZERO);
    // a slot freed in the trigger cycle is not in the latched count, so it seeds the new batch
    pend_d      = (trigger ? ZERO : pend_q) + (free_ok ? ONE : ZERO);
    err_alloc_d = err_alloc_q | (bus.slot_alloc & ~alloc_ok);
    err_free_d  = err_free_q | (bus.slot_freed & ~free_ok);
    valid_d     = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q     <= ST_INIT;
      occ_q       <= ZERO;
      pend_q      <= ZERO;
      sender_q    <= ZERO;
      latch_q     <= ZERO;
      timer_q     <= 8'd0;
      valid_q     <= 1'b0;
      err_alloc_q <= 1'b0;
      err_free_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      sender_q    <= sender_d;
      latch_q     <= latch_d;
      timer_q     <= timer_d;
      valid_q     <= valid_d;
      err_alloc_q <= err_alloc_d;
      err_free_q  <= err_free_d;
    end
  end

  assign bus.credit_return_valid = valid_q;
  assign bus.credit_return_count = latch_q;
  assign bus.occupancy           = occ_q;
  assign bus.err_alloc           = err_alloc_q;
  assign bus.err_free            = err_free_q;

endmodule

// File: tb/tb_thymesisflow_credit_return.sv
// Bench for thymesisflow_credit_return: directed scenarios with constant
// expectations plus randomized traffic against a credit-accounting model.
module tb_thymesisflow_credit_return;
  localparam int MSB = 3;
  localparam int CW  = MSB + 1;
  localparam int MAX = 8;
  localparam int THR = 4;
  localparam int TO  = 16;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  thymesisflow_credit_return_if #(.MSB(MSB)) bus ();

  thymesisflow_credit_return #(
    .MSB(MSB), .MAX_CREDITS(MAX), .RETURN_THRESHOLD(THR), .FLUSH_TIMEOUT(TO)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: credits live in exactly one place (buffer, pending batch,
  // offer on the wire, or at the sender). phase: 0 advertising, 1 idle, 2 offering.
  int m_occ, m_pend, m_sender, m_timer, m_phase, m_cnt;
  int m_valid, m_ea, m_ef;

  task automatic cycle(input logic rst, input logic al, input logic fr,
                       input logic fl, input logic rdy);
    int hs, a_ok, f_ok, trig, old_pend;
    resetn = rst;
    bus.slot_alloc = al;
    bus.slot_freed = fr;
    bus.flush = fl;
    bus.credit_return_ready = rdy;
    @(posedge clock);
    if (rst) begin
      m_occ = 0; m_pend = 0; m_sender = 0; m_timer = 0;
      m_phase = 0; m_cnt = 0; m_valid = 0; m_ea = 0; m_ef = 0;
    end else begin
      hs   = (m_valid != 0 && rdy) ? 1 : 0;
      a_ok = (al && m_sender > 0) ? 1 : 0;
      f_ok = (fr && m_occ > 0) ? 1 : 0;
      if (al && a_ok == 0) m_ea = 1;
      if (fr && f_ok == 0) m_ef = 1;
      trig = (m_phase == 1 && (m_pend >= THR || (m_pend > 0 && (fl || m_timer == TO)))) ? 1 : 0;
      m_sender = m_sender + (hs ? m_cnt : 0) - a_ok;
      m_occ = m_occ + a_ok - f_ok;
      old_pend = m_pend;
      m_pend = trig ? f_ok : m_pend + f_ok;
      if (m_phase == 1 && old_pend > 0 && !trig) m_timer = (m_timer >= TO) ? TO : m_timer + 1;
      else m_timer = 0;
      if (m_phase != 1 && hs) m_phase = 1;
      else if (trig) m_phase = 2;
      m_valid = (m_phase != 1) ? 1 : 0;
      if (m_phase == 0) m_cnt = MAX;
      else if (m_phase == 1) m_cnt = 0;
      else if (trig) m_cnt = old_pend;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_and_grant();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b0 || bus.credit_return_count !== 4'd0 ||
        bus.occupancy !== 4'd0 || bus.err_alloc !== 1'b0 || bus.err_free !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: valid=%b count=%0d occ=%0d ea=%b ef=%b, want all 0",
               bus.credit_return_valid, bus.credit_return_count, bus.occupancy,
               bus.err_alloc, bus.err_free);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.credit_return_valid !== 1'b1 || bus.credit_return_count !== 4'd8) begin
        n_bad++;
        $display("FAIL init_advert[%0d]: valid=%b count=%0d, want 1/8", i,
                 bus.credit_return_valid, bus.credit_return_count);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL init_accept: valid=%b, want 0", bus.credit_return_valid);
    end
  endtask

  task automatic test_threshold();
    int seen = 0;
    reset_and_grant();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.occupancy !== 4'd4) begin
      n_bad++;
      $display("FAIL thr_occ_fill: occ=%0d, want 4", bus.occupancy);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 && !seen; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (bus.credit_return_valid === 1'b1) seen = 1;
    end
    n_cmp++;
    if (!seen || bus.credit_return_count !== 4'd4 || bus.occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL thr_return: seen=%0d count=%0d occ=%0d, want 1/4/0", seen,
               bus.credit_return_count, bus.occupancy);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL thr_accept: valid=%b, want 0", bus.credit_return_valid);
    end
  endtask

  task automatic test_timeout_and_flush();
    int n = 0;
    reset_and_grant();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    while (n < 40 && bus.credit_return_valid !== 1'b1) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    n_cmp++;
    if (n != TO + 1 || bus.credit_return_count !== 4'd1) begin
      n_bad++;
      $display("FAIL timeout_return: cycles=%0d count=%0d, want %0d/1", n,
               bus.credit_return_count, TO + 1);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b1 || bus.credit_return_count !== 4'd1) begin
      n_bad++;
      $display("FAIL flush_return: valid=%b count=%0d, want 1/1",
               bus.credit_return_valid, bus.credit_return_count);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_free_in_send();
    reset_and_grant();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b1 || bus.credit_return_count !== 4'd1 ||
        bus.occupancy !== 4'd0) begin
      n_bad++;
      $display("FAIL send_hold: valid=%b count=%0d occ=%0d, want 1/1/0",
               bus.credit_return_valid, bus.credit_return_count, bus.occupancy);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b1 || bus.credit_return_count !== 4'd1) begin
      n_bad++;
      $display("FAIL send_carry: valid=%b count=%0d, want 1/1",
               bus.credit_return_valid, bus.credit_return_count);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_errors();
    reset_and_grant();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.err_alloc !== 1'b0 || bus.occupancy !== 4'd8) begin
      n_bad++;
      $display("FAIL alloc_legal: ea=%b occ=%0d, want 0/8", bus.err_alloc, bus.occupancy);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_cmp++;
    if (bus.err_alloc !== 1'b1 || bus.occupancy !== 4'd8) begin
      n_bad++;
      $display("FAIL alloc_err: ea=%b occ=%0d, want 1/8", bus.err_alloc, bus.occupancy);
    end
    reset_and_grant();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    n_cmp++;
    if (bus.err_free !== 1'b1 || bus.occupancy !== 4'd0 || bus.credit_return_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL free_err: ef=%b occ=%0d valid=%b, want 1/0/0", bus.err_free,
               bus.occupancy, bus.credit_return_valid);
    end
  endtask

  task automatic test_reset_in_send();
    reset_and_grant();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b0 || bus.credit_return_count !== 4'd0) begin
      n_bad++;
      $display("FAIL rst_send_drop: valid=%b count=%0d, want 0/0",
               bus.credit_return_valid, bus.credit_return_count);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (bus.credit_return_valid !== 1'b1 || bus.credit_return_count !== 4'd8) begin
      n_bad++;
      $display("FAIL rst_send_readvert: valid=%b count=%0d, want 1/8",
               bus.credit_return_valid, bus.credit_return_count);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic al, fr, fl, rdy, rst;
    reset_and_grant();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      al  = ($urandom_range(0, 9) < 4) && (m_sender > 0 || $urandom_range(0, 199) == 0);
      fr  = ($urandom_range(0, 9) < 4) && (m_occ > 0 || $urandom_range(0, 199) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 1) == 1);
      cycle(rst, al, fr, fl, rdy);
      n_cmp++;
      if (bus.credit_return_valid !== 1'(m_valid) || bus.credit_return_count !== CW'(m_cnt) ||
          bus.occupancy !== CW'(m_occ) || bus.err_alloc !== 1'(m_ea) ||
          bus.err_free !== 1'(m_ef)) begin
        n_bad++;
        $display("FAIL random[%0d]: got v=%b c=%0d o=%0d ea=%b ef=%b, want v=%0d c=%0d o=%0d ea=%0d ef=%0d",
                 i, bus.credit_return_valid, bus.credit_return_count, bus.occupancy,
                 bus.err_alloc, bus.err_free, m_valid, m_cnt, m_occ, m_ea, m_ef);
      end
    end
  endtask

  initial begin
    resetn = 1'b1;
    bus.slot_alloc = 1'b0;
    bus.slot_freed = 1'b0;
    bus.flush = 1'b0;
    bus.credit_return_ready = 1'b0;
    test_reset();
    test_threshold();
    test_timeout_and_flush();
    test_free_in_send();
    test_errors();
    test_reset_in_send();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/thymesisflow_credit_return.md
THYMESISFLOW_CREDIT_RETURN -- requirements
Module: thymesisflow_credit_return

Interface
REQ-001 SHALL provide parameter MSB, default 3, bit number of most significant bit of all credit counts.
REQ-002 SHALL provide parameter MAX_CREDITS, default 8, receive buffer depth, range 1..2^(MSB+1)-1.
REQ-003 SHALL provide parameter RETURN_THRESHOLD, default 4, pending count that triggers a return, range 1..MAX_CREDITS.
REQ-004 SHALL provide parameter FLUSH_TIMEOUT, default 16, idle cycles before a partial return, range 1..255.
REQ-005 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port resetn  input  1  synchronous, active-high reset (resetn = 1'b1 resets).
REQ-007 SHALL have port slot_alloc  input  1  one buffer slot filled by an arriving flit this cycle.
REQ-008 SHALL have port slot_freed  input  1  one buffer slot drained by downstream this cycle.
REQ-009 SHALL have port flush  input  1  return all pending credits now, ignoring threshold and timeout.
REQ-010 SHALL have port credit_return_valid  output  1  credit return offered to sender.
REQ-011 SHALL have port credit_return_count  output  MSB+1  credits carried by the offered return.
REQ-012 SHALL have port credit_return_ready  input  1  sender accepts the return this cycle.
REQ-013 SHALL have port occupancy  output  MSB+1  slots currently in use.
REQ-014 SHALL have port err_alloc  output  1  sticky: slot_alloc seen while sender held zero credits.
REQ-015 SHALL have port err_free  output  1  sticky: slot_freed seen while occupancy was zero.

Function
REQ-016 SHALL keep registered counters occupancy, pending (freed, not yet returned), sender_credits (granted, unused), each MSB+1 bits.
REQ-017 SHALL maintain occupancy + pending + sender_credits + latched return count == MAX_CREDITS whenever no error is flagged.
REQ-018 SHALL use FSM states INIT, IDLE, SEND; INIT is entered on reset.
REQ-019 SHALL, in INIT, drive credit_return_valid=1 and credit_return_count=MAX_CREDITS; on ready go to IDLE with sender_credits += MAX_CREDITS.
REQ-020 SHALL, in IDLE, trigger a return when pending >= RETURN_THRESHOLD, or flush=1 with pending>0, or timer == FLUSH_TIMEOUT with pending>0.
REQ-021 SHALL, on trigger, latch count <= pending (registered value), set pending <= slot_freed, clear the timer, and enter SEND next cycle.
REQ-022 SHALL, in SEND, hold valid=1 and count stable until ready=1; on ready add count to sender_credits and return to IDLE.
REQ-023 SHALL increment the idle timer each IDLE cycle with pending>0 and no trigger, saturating at FLUSH_TIMEOUT, and clear it otherwise.
REQ-024 SHALL, on slot_alloc, increment occupancy and decrement sender_credits in the same cycle, in any state.
REQ-025 SHALL, on slot_freed, decrement occupancy and increment pending in any state, including SEND and INIT.
REQ-026 SHALL leave occupancy unchanged when slot_alloc and slot_freed coincide.
REQ-027 SHALL, when a handshake coincides with slot_alloc, update sender_credits <= sender_credits + count - 1.
REQ-028 SHALL, on slot_alloc with sender_credits==0, set err_alloc and leave sender_credits and occupancy unchanged (no wrap).
REQ-029 SHALL, on slot_freed with occupancy==0, set err_free and leave occupancy and pending unchanged (no wrap).
REQ-030 SHALL hold err_alloc/err_free at 1 until reset.
REQ-031 SHALL register credit_return_valid and credit_return_count directly from FSM and latch, without combinational path from inputs.

Reset
REQ-032 SHALL, while resetn=1, force occupancy=0, pending=0, sender_credits=0, timer=0, latch=0, valid=0, count=0, errors=0, state=INIT.
REQ-033 SHALL assert valid=1 with count=MAX_CREDITS on the first cycle after resetn deasserts.
REQ-034 SHALL, on reset mid-operation (any state), drop any offered return and restart from INIT.

Verification
REQ-035 SHALL cover: reset release, ready=0 for 3 cycles then 1 -> valid=1, count=8 stable all 4 cycles; then valid=0, sender_credits=8.
REQ-036 SHALL cover: 4 allocs, then 4 frees -> valid=1, count=4 within 2 cycles of 4th free; after ready, sender_credits=8, occupancy=0.
REQ-037 SHALL cover: 1 alloc, 1 free, no flush -> valid=1, count=1 after 16 idle cycles; flush=1 instead -> return without waiting.
REQ-038 SHALL cover: free during SEND with ready=0 -> count unchanged, pending=1; next return carries it.
REQ-039 SHALL cover: 9th alloc with sender_credits=0 -> err_alloc=1 and sticky; free at occupancy 0 -> err_free=1, occupancy stays 0.
REQ-040 SHALL cover: resetn=1 during SEND -> valid=0 next cycle; after release, INIT re-advertises count=8.
